lcd_char_arbiter: RTL and testbench

Single-port character-RAM controller for the LCD text path. It shares one synchronous character buffer among three users: the display fetch, which is driven by the sync generator's Fila/Columna/DEN; two host writers, A and B; and a clear-screen sequencer. Display fetch always wins, so text pixels are never starved. The block sits between the sync generator and the glyph/colour stages and hands them one character code per cell.

---
 rtl/lcd_text_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/lcd_char_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_lcd_char_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_text_pkg.sv
// Shared definitions for the LCD text path: screen geometry, the blank
// character used by clear, and the clear-sequencer state encoding.
package lcd_text_pkg;

    localparam int         COLS     = 100;
    localparam int         ROWS     = 30;
    localparam int         CHAR_W   = 8;
    localparam int         CHAR_H   = 16;
    localparam int         DATA_W   = 8;
    localparam logic [7:0] CLR_CHAR = 8'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational; the
// last-grant register only advances when a grant is actually issued, so a
// disabled cycle leaves the fairness order untouched.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Set when requester 1 was granted most recently; resets set so that
    // requester 0 wins the first tie.
    logic last_b;

    // Grant a lone requester directly; on a tie grant the one not served last.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_b ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Remember who was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_b <= gnt[1];
        end
    end

endmodule

// File: rtl/lcd_char_arbiter.sv
// Single-port character-RAM controller. Each cycle the RAM goes to, in
// order: the display fetch, the clear sequencer, then the two host writers
// via round-robin. All RAM port signals are registered, so a decision taken
// in one cycle drives the RAM in the next.
module lcd_char_arbiter #(
    parameter int         COLS     = lcd_text_pkg::COLS,
    parameter int         ROWS     = lcd_text_pkg::ROWS,
    parameter int         CHAR_W   = lcd_text_pkg::CHAR_W,
    parameter int         CHAR_H   = lcd_text_pkg::CHAR_H,
    parameter int         ADDR_W   = 12,
    parameter logic [7:0] CLR_CHAR = lcd_text_pkg::CLR_CHAR
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [9:0]        Fila,
    input  logic [10:0]       Columna,
    input  logic              DEN,
    output logic [7:0]        fetch_char,
    output logic              fetch_valid,
    input  logic              wa_req,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [7:0]        wa_data,
    output logic              wa_ack,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [7:0]        wb_data,
    output logic              wb_ack,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);
    import lcd_text_pkg::*;

    localparam int                CELLS     = COLS * ROWS;
    localparam int                CW_L2     = $clog2(CHAR_W);
    localparam int                CH_L2     = $clog2(CHAR_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    // Writes beyond the visible screen are acknowledged but never reach RAM.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return int'(a) < CELLS;
    endfunction

    logic [10:0]       col_q;
    logic [9:0]        row_idx;
    logic [10:0]       col_idx;
    logic              strobe_p0;
    logic [ADDR_W-1:0] fetch_addr_p0;
    logic              vld_p1;
    logic              vld_p2;
    logic [7:0]        char_hold;

    clr_state_t        state;
    clr_state_t        state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nx;
    logic              clr_wr;

    logic              arb_en;
    logic [1:0]        arb_req;
    logic [1:0]        gnt;

    // ---- stage p0: fetch strobe and cell address from sync coordinates ----
    // Columna is compared with its registered copy so a cell held for
    // several CLK cycles (slow pixel clock) produces only one strobe.
    assign row_idx       = Fila >> CH_L2;
    assign col_idx       = Columna >> CW_L2;
    assign strobe_p0     = DEN && (Columna[CW_L2-1:0] == '0) && (Columna != col_q);
    assign fetch_addr_p0 = ADDR_W'(row_idx) * ADDR_W'(COLS) + ADDR_W'(col_idx);

    // Track the previous pixel column for edge detection.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            col_q <= '0;
        end else begin
            col_q <= Columna;
        end
    end

    // Clear sequencer state register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Clear sequencer: step one cell on every cycle the fetch leaves free.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                if (!strobe_p0) begin
                    clr_wr = 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + ADDR_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign clr_busy = (state == CLEAR);

    // A writer being acked this cycle is still holding req; masking it stops
    // the same request from being granted twice. Writers are also locked out
    // on the cycle a clear is accepted so no ack can appear while busy.
    assign arb_req = {wb_req & ~wb_ack, wa_req & ~wa_ack};
    assign arb_en  = !strobe_p0 && (state == IDLE) && !clr_req;

    rr_arbiter2 u_rr (
        .clk   (CLK),
        .rst_n (RST_n),
        .en    (arb_en),
        .req   (arb_req),
        .gnt   (gnt)
    );

    // ---- stage p1: registered RAM port and writer acks ----
    // Drive the RAM for the owner chosen this cycle.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            wa_ack    <= 1'b0;
            wb_ack    <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            wa_ack <= 1'b0;
            wb_ack <= 1'b0;
            vld_p1 <= strobe_p0;
            if (strobe_p0) begin
                ram_addr <= fetch_addr_p0;
            end else if (clr_wr) begin
                ram_addr  <= cnt;
                ram_we    <= 1'b1;
                ram_wdata <= CLR_CHAR;
            end else if (gnt[0]) begin
                ram_addr  <= wa_addr;
                ram_we    <= addr_ok(wa_addr);
                ram_wdata <= wa_data;
                wa_ack    <= 1'b1;
            end else if (gnt[1]) begin
                ram_addr  <= wb_addr;
                ram_we    <= addr_ok(wb_addr);
                ram_wdata <= wb_data;
                wb_ack    <= 1'b1;
            end
        end
    end

    // ---- stage p2: read data returns; hold the last fetched code ----
    // Capture the fetched code so fetch_char stays put between cells.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            vld_p2    <= 1'b0;
            char_hold <= CLR_CHAR;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p2) begin
                char_hold <= ram_rdata;
            end
        end
    end

    assign fetch_valid = vld_p2;
    assign fetch_char  = vld_p2 ? ram_rdata : char_hold;

endmodule

// File: tb/tb_lcd_char_arbiter.sv
// Bench for lcd_char_arbiter: a behavioural synchronous RAM, directed
// stimulus that queues its expected responses, and a monitor that pops and
// compares whenever the DUT pulses fetch_valid or a writer ack.
module tb_lcd_char_arbiter;

    localparam int ADDR_W = 12;

    logic              CLK = 1'b0;
    logic              RST_n = 1'b0;
    logic [9:0]        Fila = '0;
    logic [10:0]       Columna = '0;
    logic              DEN = 1'b0;
    logic [7:0]        fetch_char;
    logic              fetch_valid;
    logic              wa_req = 1'b0;
    logic [ADDR_W-1:0] wa_addr = '0;
    logic [7:0]        wa_data = '0;
    logic              wa_ack;
    logic              wb_req = 1'b0;
    logic [ADDR_W-1:0] wb_addr = '0;
    logic [7:0]        wb_data = '0;
    logic              wb_ack;
    logic              clr_req = 1'b0;
    logic              clr_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    lcd_char_arbiter dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .Fila        (Fila),
        .Columna     (Columna),
        .DEN         (DEN),
        .fetch_char  (fetch_char),
        .fetch_valid (fetch_valid),
        .wa_req      (wa_req),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wa_ack      (wa_ack),
        .wb_req      (wb_req),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_ack      (wb_ack),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM model; 'load' refills every cell k with k mod 256.
    logic [7:0] mem [0:4095];
    logic       load = 1'b0;
    always @(posedge CLK) begin
        if (load) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic        who;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  data;
        logic        chk_ad;
        int          cyc;
    } ack_t;
    typedef struct {
        logic [7:0] ch;
        int         cyc;
    } fet_t;

    ack_t aq[$];
    fet_t fq[$];
    ack_t ea;
    fet_t ef;
    int   ntests = 0;
    int   nfail = 0;
    int   nfetch = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_ack(input logic who, input logic we, input logic [11:0] addr,
                            input logic [7:0] data, input logic chk_ad, input int c);
        ack_t e;
        e.who = who; e.we = we; e.addr = addr; e.data = data; e.chk_ad = chk_ad; e.cyc = c;
        aq.push_back(e);
    endtask

    task automatic push_fetch(input logic [7:0] ch, input int c);
        fet_t e;
        e.ch = ch; e.cyc = c;
        fq.push_back(e);
    endtask

    // Monitor: compare every DUT response against the head of its queue.
    always @(negedge CLK) begin
        if (RST_n) begin
            if (fetch_valid) begin
                nfetch++;
                if (fq.size() == 0) begin
                    ntests++; nfail++;
                    $display("FAIL unexpected_fetch: fetch_valid with char %0h, none expected (cycle %0d)", fetch_char, cyc);
                end else begin
                    ef = fq.pop_front();
                    chk("fetch_char", 32'(fetch_char), 32'(ef.ch));
                    chk("fetch_cycle", cyc, ef.cyc);
                end
            end
            if (wa_ack || wb_ack) begin
                chk("ack_while_busy", 32'(clr_busy), 0);
                if (aq.size() == 0) begin
                    ntests++; nfail++;
                    $display("FAIL unexpected_ack: wa_ack=%0b wb_ack=%0b, none expected (cycle %0d)", wa_ack, wb_ack, cyc);
                end else begin
                    ea = aq.pop_front();
                    chk("ack_who", 32'({wb_ack, wa_ack}), ea.who ? 32'd2 : 32'd1);
                    chk("ack_ram_we", 32'(ram_we), 32'(ea.we));
                    chk("ack_cycle", cyc, ea.cyc);
                    if (ea.chk_ad) begin
                        chk("ack_ram_addr", 32'(ram_addr), 32'(ea.addr));
                        chk("ack_ram_wdata", 32'(ram_wdata), 32'(ea.data));
                    end
                end
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int n;
        int nf0;
        int bad;
        bit got;

        // Reset values
        tick(3);
        chk("rst_fetch_char", 32'(fetch_char), 32'h20);
        chk("rst_fetch_valid", 32'(fetch_valid), 0);
        chk("rst_wa_ack", 32'(wa_ack), 0);
        chk("rst_wb_ack", 32'(wb_ack), 0);
        chk("rst_clr_busy", 32'(clr_busy), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        RST_n = 1'b1;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(2);

        // Contention: A first after reset, then strict alternation
        k = cyc;
        wa_req = 1'b1; wa_addr = 12'd10; wa_data = 8'h61;
        wb_req = 1'b1; wb_addr = 12'd11; wb_data = 8'h62;
        for (int i = 0; i < 6; i++) begin
            if ((i % 2) == 0) push_ack(1'b0, 1'b1, 12'd10, 8'h61, 1'b1, k + 1 + i);
            else              push_ack(1'b1, 1'b1, 12'd11, 8'h62, 1'b1, k + 1 + i);
        end
        tick(6);
        wa_req = 1'b0; wb_req = 1'b0;
        tick(3);

        // Fetch order along text row 1 (pixel row 16)
        Fila = 10'd16; DEN = 1'b0; Columna = 11'd799;
        tick(2);
        for (int c = 0; c < 20; c++) begin
            Columna = 11'(8 * c); DEN = 1'b1;
            push_fetch(8'(100 + c), cyc + 2);
            tick(1);
            Columna = 11'(8 * c + 1);
            tick(1);
        end
        DEN = 1'b0;
        tick(4);
        chk("fetch_q_drained", fq.size(), 0);

        // Blanking: columns move but no fetches
        nf0 = nfetch;
        for (int c = 0; c <= 10; c++) begin
            Columna = 11'(8 * c);
            tick(1);
        end
        tick(3);
        chk("no_fetch_blank", nfetch - nf0, 0);

        // Single writer during blanking, then read the cell back
        k = cyc;
        wa_req = 1'b1; wa_addr = 12'd5; wa_data = 8'h41;
        push_ack(1'b0, 1'b1, 12'd5, 8'h41, 1'b1, k + 1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(1);
            got = wa_ack;
        end
        chk("single_ack_seen", 32'(got), 1);
        wa_req = 1'b0;
        tick(2);
        Fila = 10'd0; Columna = 11'd40; DEN = 1'b1;
        push_fetch(8'h41, cyc + 2);
        tick(1);
        Columna = 11'd41;
        tick(1);
        DEN = 1'b0;
        tick(3);

        // Fetch wins over a simultaneous writer; writer acked one cycle late
        k = cyc;
        Columna = 11'd16; DEN = 1'b1;
        wa_req = 1'b1; wa_addr = 12'd6; wa_data = 8'h42;
        push_fetch(8'd2, k + 2);
        push_ack(1'b0, 1'b1, 12'd6, 8'h42, 1'b1, k + 2);
        tick(1);
        chk("prio_ram_addr", 32'(ram_addr), 2);
        chk("prio_ram_we", 32'(ram_we), 0);
        chk("prio_no_ack_yet", 32'(wa_ack), 0);
        Columna = 11'd17;
        tick(1);
        wa_req = 1'b0; DEN = 1'b0;
        tick(3);

        // Out-of-range write: acked, never written
        k = cyc;
        wa_req = 1'b1; wa_addr = 12'd3000; wa_data = 8'h55;
        push_ack(1'b0, 1'b0, 12'd0, 8'h00, 1'b0, k + 1);
        tick(1);
        wa_req = 1'b0;
        tick(2);
        chk("oor_cell_kept", 32'(mem[3000]), 32'hB8);

        // Clear with ten fetches landing inside it and writer B waiting
        Fila = 10'd320; DEN = 1'b0; Columna = 11'd799;
        tick(1);
        k = cyc;
        clr_req = 1'b1;
        wb_req = 1'b1; wb_addr = 12'd7; wb_data = 8'h77;
        push_ack(1'b1, 1'b1, 12'd7, 8'h77, 1'b1, k + 3012);
        tick(1);
        clr_req = 1'b0;
        chk("clr_busy_rise", 32'(clr_busy), 1);
        tick(1);
        for (int c = 0; c < 10; c++) begin
            Columna = 11'(8 * c); DEN = 1'b1;
            push_fetch(8'(208 + c), cyc + 2);
            tick(1);
            Columna = 11'(8 * c + 1);
            if (c == 4) clr_req = 1'b1;
            tick(3);
            clr_req = 1'b0;
        end
        DEN = 1'b0;
        n = 0;
        while (clr_busy && n < 6000) begin
            tick(1);
            n++;
        end
        chk("clr_busy_length", cyc - (k + 1), 3010);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            got = wb_ack;
            if (!got) tick(1);
        end
        chk("clr_then_wb_ack", 32'(got), 1);
        wb_req = 1'b0;
        tick(3);
        bad = 0;
        for (int a = 0; a < 3000; a++) begin
            if (a != 7 && mem[a] !== 8'h20) bad++;
        end
        chk("clear_all_cells", bad, 0);
        chk("clear_cell7_written", 32'(mem[7]), 32'h77);
        chk("clear_no_overrun", 32'(mem[3000]), 32'hB8);

        // Reset halfway through a clear
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        tick(1499);
        chk("midclr_busy", 32'(clr_busy), 1);
        RST_n = 1'b0;
        #1;
        chk("midclr_rst_busy", 32'(clr_busy), 0);
        chk("midclr_rst_we", 32'(ram_we), 0);
        tick(2);
        RST_n = 1'b1;
        tick(3);
        chk("midclr_busy_stays_low", 32'(clr_busy), 0);
        chk("midclr_low_cleared", 32'(mem[1000]), 32'h20);
        chk("midclr_high_kept", 32'(mem[2000]), 32'hD0);
        chk("midclr_top_kept", 32'(mem[2999]), 32'hB7);

        tick(3);
        chk("ack_q_drained", aq.size(), 0);
        chk("fetch_q_empty", fq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
